// File: rtl/trellis_acq_pkg.sv
// ----------------------------------------------------------------------------
// trellis_acq_pkg
// Shared definitions for the carrier acquisition sequencer:
//   - acq_state_t : acquisition state encoding. The encoding is also the
//                   value reported on the status port.
//   - sat_abs     : saturating absolute value of a sign-extended operand of
//                   a given width.
// ----------------------------------------------------------------------------
package trellis_acq_pkg;

   localparam int ACQ_STATE_W = 2;

   typedef enum logic [ACQ_STATE_W-1:0] {
      ST_IDLE   = 2'd0,
      ST_SWEEP  = 2'd1,
      ST_VERIFY = 2'd2,
      ST_LOCKED = 2'd3
   } acq_state_t;

   // |x| for a w-bit two's complement value that has been sign-extended to
   // 32 bits. The most-negative w-bit value has no positive counterpart, so
   // it is clamped to the largest positive w-bit value.
   function automatic logic [31:0] sat_abs(input logic signed [31:0] x,
                                           input int                 w);
      logic signed [31:0] most_neg;
      most_neg = -(32'sd1 <<< (w - 1));
      if (x == most_neg)
         return (32'd1 << (w - 1)) - 32'd1;
      else if (x < 0)
         return 32'(-x);
      else
         return 32'(x);
   endfunction

endpackage

// File: rtl/trellis_acq_ctrl_err_window.sv
// ----------------------------------------------------------------------------
// trellis_err_window
// Integrates |phaseError| over windows of 2^WIN_LOG2 symbols.
//
// Ports:
//   i_clk         system clock
//   i_reset       asynchronous active-high reset
//   i_sym_en      symbol enable; i_phase_error is valid while high
//   i_clear       discards the partial window (accumulator and counter to 0)
//   i_phase_error signed phase error, SIZE bits
//   o_win_done    combinational pulse on the symbol that completes a window
//   o_sum         accumulator plus the current magnitude. On the o_win_done
//                 cycle this is the completed window sum.
// ----------------------------------------------------------------------------
module trellis_err_window
   import trellis_acq_pkg::*;
#(
   parameter int SIZE     = 8,
   parameter int WIN_LOG2 = 4
) (
   input  logic                       i_clk,
   input  logic                       i_reset,
   input  logic                       i_sym_en,
   input  logic                       i_clear,
   input  logic signed [SIZE-1:0]     i_phase_error,
   output logic                       o_win_done,
   output logic [SIZE+WIN_LOG2-1:0]   o_sum
);

   localparam int SUM_W = SIZE + WIN_LOG2;

   logic [SUM_W-1:0]    r_acc;
   logic [WIN_LOG2-1:0] r_cnt;
   logic [SIZE-1:0]     w_mag;
   logic                w_last_sym;

   // The magnitude is at most 2^(SIZE-1)-1. Therefore 2^WIN_LOG2 of them
   // always fit in SUM_W bits.
   assign w_mag      = SIZE'(sat_abs(32'(i_phase_error), SIZE));
   assign o_sum      = r_acc + {{WIN_LOG2{1'b0}}, w_mag};
   assign w_last_sym = (r_cnt == {WIN_LOG2{1'b1}});
   // A cleared cycle never completes a window. Re-entry from IDLE therefore
   // always starts a fresh, full window.
   assign o_win_done = i_sym_en && !i_clear && w_last_sym;

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_acc <= '0;
         r_cnt <= '0;
      end else if (i_clear) begin
         r_acc <= '0;
         r_cnt <= '0;
      end else if (i_sym_en) begin
         r_acc <= w_last_sym ? '0 : o_sum;
         r_cnt <= r_cnt + 1'b1;   // wraps to 0 after the last symbol
      end
   end

endmodule

// File: rtl/trellis_acq_ctrl.sv
// ----------------------------------------------------------------------------
// trellis_acq_ctrl
// Carrier acquisition sequencer. It integrates |phaseError| over fixed
// symbol windows. While the error energy stays high it steps a frequency
// sweep offset into the carrier NCO. Once a good window is seen, it verifies
// lock over VERIFY_WINS further windows. It then switches the loop to track
// gain and watches for loss of lock.
//
// Ports:
//   i_clk            system clock
//   i_reset          asynchronous active-high reset
//   i_sym_en         symbol-rate enable
//   i_enable         acquisition enable (low holds the block in IDLE)
//   i_phase_error    signed carrier-loop phase error, SIZE bits
//   i_sweep_step     unsigned offset increment per failed window
//   i_sweep_limit    unsigned sweep bound; the offset stays within +/- limit
//   i_lock_thresh    window sum below this is good (SWEEP/VERIFY)
//   i_unlock_thresh  window sum above this is bad (LOCKED)
//   o_sweep_offset   signed NCO frequency offset
//   o_gain_sel       0 = acquire gain, 1 = track gain
//   o_lock_detect    high while LOCKED
//   o_acq_state      0 IDLE, 1 SWEEP, 2 VERIFY, 3 LOCKED
//   o_window_sum     last completed window sum
// ----------------------------------------------------------------------------
module trellis_acq_ctrl
   import trellis_acq_pkg::*;
#(
   parameter int SIZE        = 8,
   parameter int WIN_LOG2    = 4,
   parameter int VERIFY_WINS = 4,
   parameter int MISS_LIMIT  = 3,
   parameter int OFF_BITS    = 16
) (
   input  logic                       i_clk,
   input  logic                       i_reset,
   input  logic                       i_sym_en,
   input  logic                       i_enable,
   input  logic signed [SIZE-1:0]     i_phase_error,
   input  logic [OFF_BITS-2:0]        i_sweep_step,
   input  logic [OFF_BITS-2:0]        i_sweep_limit,
   input  logic [SIZE+WIN_LOG2-1:0]   i_lock_thresh,
   input  logic [SIZE+WIN_LOG2-1:0]   i_unlock_thresh,
   output logic signed [OFF_BITS-1:0] o_sweep_offset,
   output logic                       o_gain_sel,
   output logic                       o_lock_detect,
   output logic [1:0]                 o_acq_state,
   output logic [SIZE+WIN_LOG2-1:0]   o_window_sum
);

   localparam int SUM_W  = SIZE + WIN_LOG2;
   localparam int GOOD_W = $clog2(VERIFY_WINS + 1);
   localparam int MISS_W = $clog2(MISS_LIMIT + 1);

   acq_state_t                 r_state;
   logic signed [OFF_BITS-1:0] r_offset;
   logic                       r_gain_sel;
   logic                       r_lock_detect;
   logic [SUM_W-1:0]           r_window_sum;
   logic [GOOD_W-1:0]          r_good_cnt;
   logic [MISS_W-1:0]          r_miss_cnt;

   logic                       w_clear;
   logic                       w_win_done;
   logic [SUM_W-1:0]           w_win_sum;
   logic                       w_good_win;
   logic                       w_bad_win;
   logic signed [OFF_BITS:0]   w_next_ext;
   logic signed [OFF_BITS:0]   w_limit_ext;
   logic signed [OFF_BITS-1:0] w_step_offset;

   // The window restarts whenever we are, or are about to be, idle.
   assign w_clear = !i_enable || (r_state == ST_IDLE);

   trellis_err_window #(
      .SIZE     (SIZE),
      .WIN_LOG2 (WIN_LOG2)
   ) u_err_window (
      .i_clk         (i_clk),
      .i_reset       (i_reset),
      .i_sym_en      (i_sym_en),
      .i_clear       (w_clear),
      .i_phase_error (i_phase_error),
      .o_win_done    (w_win_done),
      .o_sum         (w_win_sum)
   );

   // Decisions use the fresh sum, not the registered status copy.
   assign w_good_win = (w_win_sum < i_lock_thresh);
   assign w_bad_win  = (w_win_sum > i_unlock_thresh);

   // The sweep step is computed one bit wider so that offset + step cannot
   // wrap before it is compared against the positive bound.
   assign w_next_ext  = $signed({r_offset[OFF_BITS-1], r_offset})
                      + $signed({2'b00, i_sweep_step});
   assign w_limit_ext = $signed({2'b00, i_sweep_limit});

   always_comb begin
      w_step_offset = w_next_ext[OFF_BITS-1:0];
      if (w_next_ext > w_limit_ext)
         w_step_offset = -$signed({1'b0, i_sweep_limit});
   end

   // The good counter counts the qualifying SWEEP window as 1. Lock is
   // declared on the VERIFY_WINS-th good window spent in VERIFY itself,
   // which is when a good window arrives with the counter at VERIFY_WINS.
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_state       <= ST_IDLE;
         r_offset      <= '0;
         r_gain_sel    <= 1'b0;
         r_lock_detect <= 1'b0;
         r_window_sum  <= '0;
         r_good_cnt    <= '0;
         r_miss_cnt    <= '0;
      end else if (!i_enable) begin
         // The window sum is status only; it keeps its last value.
         r_state       <= ST_IDLE;
         r_offset      <= '0;
         r_gain_sel    <= 1'b0;
         r_lock_detect <= 1'b0;
         r_good_cnt    <= '0;
         r_miss_cnt    <= '0;
      end else begin
         if (w_win_done)
            r_window_sum <= w_win_sum;

         case (r_state)
            ST_IDLE: begin
               r_state <= ST_SWEEP;
            end

            ST_SWEEP: begin
               if (w_win_done) begin
                  if (w_good_win) begin
                     r_state    <= ST_VERIFY;
                     r_good_cnt <= GOOD_W'(1);
                  end else begin
                     r_offset <= w_step_offset;
                  end
               end
            end

            ST_VERIFY: begin
               if (w_win_done) begin
                  if (w_good_win) begin
                     if (r_good_cnt == GOOD_W'(VERIFY_WINS)) begin
                        r_state       <= ST_LOCKED;
                        r_gain_sel    <= 1'b1;
                        r_lock_detect <= 1'b1;
                        r_good_cnt    <= '0;
                        r_miss_cnt    <= '0;
                     end else begin
                        r_good_cnt <= r_good_cnt + 1'b1;
                     end
                  end else begin
                     r_state    <= ST_SWEEP;
                     r_offset   <= w_step_offset;
                     r_good_cnt <= '0;
                  end
               end
            end

            ST_LOCKED: begin
               if (w_win_done) begin
                  if (w_bad_win) begin
                     if (r_miss_cnt == MISS_W'(MISS_LIMIT - 1)) begin
                        // The sweep resumes from the current offset.
                        r_state       <= ST_SWEEP;
                        r_gain_sel    <= 1'b0;
                        r_lock_detect <= 1'b0;
                        r_miss_cnt    <= '0;
                     end else begin
                        r_miss_cnt <= r_miss_cnt + 1'b1;
                     end
                  end else begin
                     r_miss_cnt <= '0;
                  end
               end
            end

            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign o_sweep_offset = r_offset;
   assign o_gain_sel     = r_gain_sel;
   assign o_lock_detect  = r_lock_detect;
   assign o_acq_state    = r_state;
   assign o_window_sum   = r_window_sum;

endmodule

// File: tb/tb_trellis_acq_ctrl.sv
// ----------------------------------------------------------------------------
// tb_trellis_acq_ctrl
// Directed bench for trellis_acq_ctrl with default parameters. After every
// stimulus cycle the stimulus side queues the hand-computed status that the
// design must show. A monitor pops queued entries and compares them against
// the outputs, either at the falling clock edge or on an explicit kick used
// for the mid-cycle reset check.
// ----------------------------------------------------------------------------
module tb_trellis_acq_ctrl;

   logic               clk;
   logic               reset;
   logic               sym_en;
   logic               enable;
   logic signed [7:0]  phase_error;
   logic [14:0]        sweep_step;
   logic [14:0]        sweep_limit;
   logic [11:0]        lock_thresh;
   logic [11:0]        unlock_thresh;
   logic signed [15:0] sweep_offset;
   logic               gain_sel;
   logic               lock_detect;
   logic [1:0]         acq_state;
   logic [11:0]        window_sum;

   trellis_acq_ctrl dut (
      .i_clk           (clk),
      .i_reset         (reset),
      .i_sym_en        (sym_en),
      .i_enable        (enable),
      .i_phase_error   (phase_error),
      .i_sweep_step    (sweep_step),
      .i_sweep_limit   (sweep_limit),
      .i_lock_thresh   (lock_thresh),
      .i_unlock_thresh (unlock_thresh),
      .o_sweep_offset  (sweep_offset),
      .o_gain_sel      (gain_sel),
      .o_lock_detect   (lock_detect),
      .o_acq_state     (acq_state),
      .o_window_sum    (window_sum)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      int          tag;
      string       name;
      logic [1:0]  st;
      logic [15:0] off;
      logic        gain;
      logic        lock;
      logic [11:0] ws;
   } exp_t;

   exp_t        sb_q[$];
   exp_t        mon_e;
   int          edge_cnt = 0;
   int          n_vec    = 0;
   int          n_err    = 0;
   logic        kick     = 1'b0;

   // Current expected status, updated by hand in the stimulus.
   logic [1:0]  exp_st   = 2'd0;
   logic [15:0] exp_off  = 16'h0000;
   logic        exp_gain = 1'b0;
   logic        exp_lock = 1'b0;
   logic [11:0] exp_ws   = 12'd0;
   string       cur_name = "reset";

   always @(posedge clk) edge_cnt <= edge_cnt + 1;

   // Monitor / scoreboard
   always @(negedge clk or posedge kick) begin
      while (sb_q.size() > 0 && sb_q[0].tag <= edge_cnt) begin
         mon_e = sb_q.pop_front();
         n_vec++;
         if (acq_state !== mon_e.st || sweep_offset !== mon_e.off ||
             gain_sel !== mon_e.gain || lock_detect !== mon_e.lock ||
             window_sum !== mon_e.ws) begin
            n_err++;
            $display("FAIL %s @edge %0d: got st=%0d off=%h gain=%b lock=%b ws=%0d, expected st=%0d off=%h gain=%b lock=%b ws=%0d",
                     mon_e.name, mon_e.tag, acq_state, sweep_offset, gain_sel,
                     lock_detect, window_sum, mon_e.st, mon_e.off, mon_e.gain,
                     mon_e.lock, mon_e.ws);
         end else begin
            $display("ok   %s @edge %0d: st=%0d off=%h gain=%b lock=%b ws=%0d",
                     mon_e.name, mon_e.tag, acq_state, sweep_offset, gain_sel,
                     lock_detect, window_sum);
         end
      end
   end

   task automatic set_exp(input logic [1:0] st, input logic [15:0] off,
                          input logic g, input logic l, input logic [11:0] ws);
      exp_st = st; exp_off = off; exp_gain = g; exp_lock = l; exp_ws = ws;
   endtask

   task automatic push();
      exp_t e;
      e.tag = edge_cnt; e.name = cur_name; e.st = exp_st; e.off = exp_off;
      e.gain = exp_gain; e.lock = exp_lock; e.ws = exp_ws;
      sb_q.push_back(e);
   endtask

   // One clock of stimulus, then queue the expected post-edge status.
   task automatic step(input logic s, input int pe);
      sym_en      = s;
      phase_error = 8'(pe);
      @(posedge clk);
      #1;
      push();
   endtask

   // A full 16-symbol window. The expected status changes only on the last
   // symbol. With gap set, an idle cycle carrying a large garbage error is
   // inserted mid-window.
   task automatic run_window(input int pe, input bit alt, input bit gap,
                             input logic [1:0] st, input logic [15:0] off,
                             input logic g, input logic l,
                             input logic [11:0] ws, input string nm);
      for (int i = 0; i < 16; i++) begin
         if (gap && i == 7) begin
            cur_name = {nm, "_gap"};
            step(1'b0, 127);
         end
         if (i == 15) set_exp(st, off, g, l, ws);
         cur_name = nm;
         step(1'b1, (alt && i[0]) ? -pe : pe);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish, expected finish before timeout");
      $fatal(1, "timeout");
   end

   initial begin
      reset = 1'b1; enable = 1'b0; sym_en = 1'b0; phase_error = '0;
      sweep_step = 15'h0100; sweep_limit = 15'h0400;
      lock_thresh = 12'd200; unlock_thresh = 12'd800;

      // Reset and idle
      cur_name = "reset_hold";
      step(1'b0, 0);
      step(1'b1, 50);
      reset = 1'b0;
      cur_name = "idle_disabled";
      step(1'b1, 50);
      enable = 1'b1;
      set_exp(2'd1, 16'h0000, 1'b0, 1'b0, 12'd0);
      cur_name = "enter_sweep";
      step(1'b0, 0);

      // Sweep with wrap at the bound: 16 x 100 = 1600 per window
      run_window(100, 1, 1, 2'd1, 16'h0100, 0, 0, 12'd1600, "sweep1");
      run_window(100, 1, 0, 2'd1, 16'h0200, 0, 0, 12'd1600, "sweep2");
      run_window(100, 1, 0, 2'd1, 16'h0300, 0, 0, 12'd1600, "sweep3");
      run_window(100, 1, 0, 2'd1, 16'h0400, 0, 0, 12'd1600, "sweep4");
      run_window(100, 1, 1, 2'd1, 16'hFC00, 0, 0, 12'd1600, "sweep_wrap");

      // Acquisition: 16 x 5 = 80 < 200
      run_window(5, 0, 0, 2'd2, 16'hFC00, 0, 0, 12'd80, "verify_enter");
      run_window(5, 1, 0, 2'd2, 16'hFC00, 0, 0, 12'd80, "verify_w1");
      run_window(5, 0, 0, 2'd2, 16'hFC00, 0, 0, 12'd80, "verify_w2");
      run_window(5, 0, 1, 2'd2, 16'hFC00, 0, 0, 12'd80, "verify_w3");
      run_window(5, 0, 0, 2'd3, 16'hFC00, 1, 1, 12'd80, "locked");

      // Loss of lock: 1600 > 800 is a miss, 80 clears the count
      run_window(100, 0, 0, 2'd3, 16'hFC00, 1, 1, 12'd1600, "miss1");
      run_window(100, 0, 0, 2'd3, 16'hFC00, 1, 1, 12'd1600, "miss2");
      run_window(5,   0, 0, 2'd3, 16'hFC00, 1, 1, 12'd80,   "miss_clear");
      run_window(100, 0, 0, 2'd3, 16'hFC00, 1, 1, 12'd1600, "miss1b");
      run_window(100, 0, 0, 2'd3, 16'hFC00, 1, 1, 12'd1600, "miss2b");
      run_window(100, 0, 0, 2'd1, 16'hFC00, 0, 0, 12'd1600, "unlock");

      // Saturation: -128 counts as 127; the bad window steps FC00 -> FD00
      run_window(-128, 0, 0, 2'd1, 16'hFD00, 0, 0, 12'd2032, "saturate");

      // Abort mid-window in VERIFY, then re-enable
      run_window(5, 0, 0, 2'd2, 16'hFD00, 0, 0, 12'd80, "reverify");
      cur_name = "partial";
      for (int i = 0; i < 8; i++) step(1'b1, 5);
      enable = 1'b0;
      set_exp(2'd0, 16'h0000, 1'b0, 1'b0, 12'd80);
      cur_name = "abort";
      step(1'b1, 5);
      cur_name = "idle_hold";
      step(1'b1, 127);
      enable = 1'b1;
      set_exp(2'd1, 16'h0000, 1'b0, 1'b0, 12'd80);
      cur_name = "reenter";
      step(1'b0, 0);
      run_window(3, 0, 0, 2'd2, 16'h0000, 0, 0, 12'd48, "first_window");

      // Asynchronous reset between clock edges, checked before the next edge
      @(negedge clk);
      #1;
      reset = 1'b1;
      #1;
      set_exp(2'd0, 16'h0000, 1'b0, 1'b0, 12'd0);
      cur_name = "async_reset";
      push();
      kick = 1'b1;
      #1;
      kick = 1'b0;
      @(posedge clk);
      #1;
      reset = 1'b0;
      set_exp(2'd1, 16'h0000, 1'b0, 1'b0, 12'd0);
      cur_name = "post_reset";
      step(1'b0, 0);

      // Drain
      repeat (3) @(negedge clk);
      #1;
      if (sb_q.size() != 0) begin
         $display("FAIL drain: got %0d unchecked entries, expected 0", sb_q.size());
         n_err++;
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/trellis_acq_ctrl.md
Name: trellis_acq_ctrl

Overview:
Carrier acquisition sequencer for the trellis demodulator. It integrates |phaseError| from the carrier loop over fixed symbol windows and steps a frequency-sweep offset into the carrier loop NCO until the error energy drops below a lock threshold. It then verifies lock over several windows, switches the carrier loop from acquire gain to track gain, and monitors for loss of lock. It sits beside the carrier loop and is clocked on symEn.

Parameters:
SIZE, 8, width of the signed phaseError input.
WIN_LOG2, 4, log2 of the integration window length in symbols (default window is 16 symbols).
VERIFY_WINS, 4, consecutive good windows required in VERIFY before LOCKED is declared.
MISS_LIMIT, 3, consecutive bad windows in LOCKED before lock is dropped.
OFF_BITS, 16, width of the signed sweep offset.

Ports:
clk  in  1  system clock.
reset  in  1  asynchronous, active-high reset.
symEn  in  1  symbol-rate enable; phaseError is valid when it is high.
enable  in  1  acquisition enable; when low the block is held in IDLE.
phaseError  in  SIZE  signed carrier-loop phase error.
sweepStep  in  OFF_BITS-1  unsigned offset increment applied per failed window.
sweepLimit  in  OFF_BITS-1  unsigned sweep bound; the sweep range is ±sweepLimit.
lockThresh  in  SIZE+WIN_LOG2  unsigned; a window sum below this value is a good window in SWEEP and VERIFY.
unlockThresh  in  SIZE+WIN_LOG2  unsigned; a window sum above this value is a bad window in LOCKED.
sweepOffset  out  OFF_BITS  signed frequency offset to the carrier loop NCO.
gainSel  out  1  loop gain select: 0 = acquire, 1 = track.
lockDetect  out  1  high while in the LOCKED state.
acqState  out  2  current state: 0 IDLE, 1 SWEEP, 2 VERIFY, 3 LOCKED.
windowSum  out  SIZE+WIN_LOG2  most recent completed window sum, for status readback.

Behaviour:
- Reset (async) forces all outputs to 0, the state to IDLE, and all counters and the accumulator to 0.
- Magnitude: |phaseError|, with the most-negative input (-2^(SIZE-1)) saturated to 2^(SIZE-1)-1.
- Accumulator width is SIZE+WIN_LOG2 and it cannot overflow.
- Accumulation: on each symEn the accumulator adds the magnitude and the symbol counter increments.
- Window end: the symEn where the counter equals 2^WIN_LOG2-1. On that edge:
  - windowSum <= acc + mag;
  - acc <= 0 and the counter wraps to 0;
  - the state decision uses acc + mag (the new sum), not the registered windowSum.
  - State and output changes on window end occur on the same clock edge; latency from the last symbol to the state change is 0 cycles after registration.
- Sweep step: next = offset + sweepStep, computed with one extra bit. If next > +sweepLimit, offset <= -sweepLimit; otherwise offset <= next.
- IDLE: offset = 0, gainSel = 0, lockDetect = 0, accumulator cleared. enable=1 -> SWEEP on the next clk; the window starts from 0.
- SWEEP: at window end:
  - sum < lockThresh -> VERIFY, offset held, good counter = 1;
  - otherwise apply a sweep step and stay in SWEEP.
- VERIFY: at window end:
  - a good window increments the good counter; reaching VERIFY_WINS -> LOCKED, with gainSel = 1 and lockDetect = 1 on the same edge;
  - a bad window -> SWEEP and a sweep step is applied.
- LOCKED: at window end:
  - sum > unlockThresh increments the miss counter; otherwise the miss counter clears;
  - miss counter reaching MISS_LIMIT -> SWEEP with gainSel = 0, lockDetect = 0, offset unchanged (the sweep resumes from the current offset).
- VERIFY_WINS = 1 is legal: a good window in SWEEP enters VERIFY, and the next good window locks.
- enable=0 in any state -> IDLE on the next clk, with all outputs and counters cleared as in IDLE; windowSum holds its last value.
- Mid-window entry from IDLE always starts a full window; partial windows are discarded.
- symEn low: nothing advances; outputs are stable.
- acqState encodes the state directly; there are no illegal states (2 bits, 4 states).

Decomposition:
- Package trellis_acq_pkg holds:
  - the state encodings ST_IDLE, ST_SWEEP, ST_VERIFY, ST_LOCKED;
  - a function for the saturating absolute value.
- Sub-module trellis_err_window contains the abs, the accumulator, and the window counter. It outputs winDone (a 1-cycle pulse) and sum, and takes a clear input.
- The FSM, sweep arithmetic, and good/miss counters stay in trellis_acq_ctrl.

Test Plan:
- Reset check: assert reset asynchronously mid-clock -> sweepOffset=0, gainSel=0, lockDetect=0, acqState=0, windowSum=0 immediately.
- Sweep and wrap: enable=1, phaseError alternating +100/-100, lockThresh=200, sweepStep=0x100, sweepLimit=0x400 -> offset 0x100, 0x200, 0x300, 0x400, then 0xFC00 (-0x400) after successive 16-symEn windows; windowSum=1600.
- Acquisition: from SWEEP, phaseError=5 (sum 80), lockThresh=200 -> VERIFY at the first window end, LOCKED after 4 more windows (80 symEn total); gainSel=lockDetect=1; offset frozen.
- Loss of lock: in LOCKED, unlockThresh=800, phaseError=100 for 2 windows then 5 for 1 window -> stays LOCKED; then 3 consecutive windows at 100 -> SWEEP, lockDetect=0, gainSel=0.
- Saturation: phaseError=-128 for a full window -> windowSum=2032 (16×127), no wrap.
- Abort: enable dropped in VERIFY mid-window -> IDLE next clk, offset=0; re-enable -> the first window completes exactly 16 symEn later.
